// File: rtl/csr_def.sv
`default_nettype none
// ============================================================================
// Package     : csr_def
// Description : Shared CSR address constants and TCFG field indices for the
//               timer bank. Channel n registers sit at <BASE> + n*CH_STRIDE.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_def;

  localparam logic [13:0] TCFG_BASE  = 14'h041;
  localparam logic [13:0] TVAL_BASE  = 14'h042;
  localparam logic [13:0] TICLR_BASE = 14'h044;
  localparam logic [13:0] CH_STRIDE  = 14'h008;
  localparam logic [13:0] CNTVL      = 14'h0C0;
  localparam logic [13:0] CNTVH      = 14'h0C1;

  // TCFG field indices
  localparam int TCFG_EN       = 0;
  localparam int TCFG_PERIODIC = 1;

  localparam int MAX_TIMERS = 8;

  // Address of channel n's register whose channel-0 address is base.
  function automatic logic [13:0] chan_addr(input logic [13:0] base, input int n);
    return base + 14'(n) * CH_STRIDE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_timer_chan.sv
`default_nettype none
// ============================================================================
// Module      : csr_timer_chan
// Description : One timer channel: TCFG field, down-counter and pending flag.
//               Address decode is done by the parent; this block only sees
//               the per-channel write strobes.
// Ports       : clk, rst      - clock, async active-high reset
//               cfg_we        - TCFG write to this channel (takes wd)
//               clr_we        - TICLR write to this channel with WD[0]=1
//               wd            - write data, already cut to TIMER_WIDTH bits
//               cfg / timer   - stored TCFG field and current count
//               pending       - registered expiry flag
// Revision    : 1.0 - initial release
// ============================================================================
module csr_timer_chan
  import csr_def::*;
#(
  parameter int TIMER_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic                   clr_we,
  input  logic [TIMER_WIDTH-1:0] wd,
  output logic [TIMER_WIDTH-1:0] cfg,
  output logic [TIMER_WIDTH-1:0] timer,
  output logic                   pending
);

  logic [TIMER_WIDTH-1:0] cfg_q, cfg_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   pending_q, pending_d;
  logic                   expire;

  assign expire = cfg_q[TCFG_EN] && (timer_q == '0);

  always_comb begin
    cfg_d     = cfg_q;
    timer_d   = timer_q;
    pending_d = pending_q;

    if (cfg_q[TCFG_EN]) begin
      if (!expire) begin
        timer_d = timer_q - TIMER_WIDTH'(1);
      end else if (cfg_q[TCFG_PERIODIC]) begin
        timer_d = {cfg_q[TIMER_WIDTH-1:2], 2'b00};
      end else begin
        cfg_d[TCFG_EN] = 1'b0;  // one-shot: disarm, count stays at zero
      end
    end

    // A config write overrides whatever the running channel would do this
    // edge; with En cleared the count is frozen at its current value.
    if (cfg_we) begin
      cfg_d = wd;
      if (wd[TCFG_EN]) begin
        timer_d = {wd[TIMER_WIDTH-1:2], 2'b00};
      end else begin
        timer_d = timer_q;
      end
    end

    if (clr_we) begin
      pending_d = 1'b0;
    end
    // Expiry is applied last so it beats a same-edge clear.
    if (expire) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q     <= '0;
      timer_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      cfg_q     <= cfg_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
    end
  end

  assign cfg     = cfg_q;
  assign timer   = timer_q;
  assign pending = pending_q;

endmodule
`default_nettype wire

// File: rtl/csr_timer_bank.sv
`default_nettype none
// ============================================================================
// Module      : csr_timer_bank
// Description : Multi-channel CSR timer bank with a free-running stable
//               counter. Holds address decode, the counter, the read mux
//               (with write-to-read bypass on TCFG) and the IRQ encoder.
// Ports       : clk, rst                - clock, async active-high reset
//               csr_write, write_addr, WD - WB-stage CSR write port
//               read_addr, RDout        - EX-stage CSR read port (comb.)
//               timer_irq               - per-channel pending bits
//               timer_int               - OR of timer_irq
//               timer_id                - lowest pending channel, 0 if none
// Revision    : 1.0 - initial release
// ============================================================================
module csr_timer_bank
  import csr_def::*;
#(
  parameter int NUM_TIMERS  = 2,
  parameter int TIMER_WIDTH = 32,
  parameter int CNT_WIDTH   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csr_write,
  input  logic [13:0]           write_addr,
  input  logic [31:0]           WD,
  input  logic [13:0]           read_addr,
  output logic [31:0]           RDout,
  output logic [NUM_TIMERS-1:0] timer_irq,
  output logic                  timer_int,
  output logic [2:0]            timer_id
);

  logic [NUM_TIMERS-1:0][TIMER_WIDTH-1:0] chan_cfg;
  logic [NUM_TIMERS-1:0][TIMER_WIDTH-1:0] chan_timer;
  logic [NUM_TIMERS-1:0]                  chan_pending;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          rd_data;
  logic [2:0]           irq_id;

  generate
    for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_chan
      logic cfg_we;
      logic clr_we;

      assign cfg_we = csr_write && (write_addr == chan_addr(TCFG_BASE, g));
      assign clr_we = csr_write && (write_addr == chan_addr(TICLR_BASE, g)) && WD[0];

      csr_timer_chan #(
        .TIMER_WIDTH (TIMER_WIDTH)
      ) u_chan (
        .clk     (clk),
        .rst     (rst),
        .cfg_we  (cfg_we),
        .clr_we  (clr_we),
        .wd      (WD[TIMER_WIDTH-1:0]),
        .cfg     (chan_cfg[g]),
        .timer   (chan_timer[g]),
        .pending (chan_pending[g])
      );
    end
  endgenerate

  // Stable counter: free-running, not writable.
  assign cnt_d = cnt_q + CNT_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Read mux. TICLR and anything unmatched fall through as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (read_addr == chan_addr(TCFG_BASE, i)) begin
        rd_data[TIMER_WIDTH-1:0] = chan_cfg[i];
      end
      if (read_addr == chan_addr(TVAL_BASE, i)) begin
        rd_data[TIMER_WIDTH-1:0] = chan_timer[i];
      end
      // Same-cycle WB write to the TCFG being read in EX: forward the new value.
      if (csr_write && (write_addr == read_addr) &&
          (read_addr == chan_addr(TCFG_BASE, i))) begin
        rd_data                  = '0;
        rd_data[TIMER_WIDTH-1:0] = WD[TIMER_WIDTH-1:0];
      end
    end
    if (read_addr == CNTVL) begin
      rd_data = cnt_q[31:0];
    end
    if (read_addr == CNTVH) begin
      rd_data                = '0;
      rd_data[CNT_WIDTH-33:0] = cnt_q[CNT_WIDTH-1:32];
    end
  end

  // Lowest-index pending channel wins; scanning downward leaves the lowest.
  always_comb begin
    irq_id = '0;
    for (int i = NUM_TIMERS - 1; i >= 0; i--) begin
      if (chan_pending[i]) begin
        irq_id = 3'(i);
      end
    end
  end

  assign RDout     = rd_data;
  assign timer_irq = chan_pending;
  assign timer_int = |chan_pending;
  assign timer_id  = irq_id;

endmodule
`default_nettype wire

// File: tb/tb_csr_timer_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_timer_bank
// Description : Self-checking bench for csr_timer_bank (2 channels, 32-bit
//               timers, 64-bit counter). Expected values are queued when the
//               stimulus is applied and popped when the output is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_csr_timer_bank;

  localparam logic [13:0] A_TCFG0  = 14'h041;
  localparam logic [13:0] A_TVAL0  = 14'h042;
  localparam logic [13:0] A_TICLR0 = 14'h044;
  localparam logic [13:0] A_TCFG1  = 14'h049;
  localparam logic [13:0] A_TVAL1  = 14'h04A;
  localparam logic [13:0] A_TICLR1 = 14'h04C;
  localparam logic [13:0] A_TCFG2  = 14'h051;
  localparam logic [13:0] A_CNTVL  = 14'h0C0;
  localparam logic [13:0] A_CNTVH  = 14'h0C1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_write = 1'b0;
  logic [13:0] write_addr = '0;
  logic [31:0] WD = '0;
  logic [13:0] read_addr = '0;
  logic [31:0] RDout;
  logic [1:0]  timer_irq;
  logic        timer_int;
  logic [2:0]  timer_id;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int unsigned edge_cnt = 0;

  csr_timer_bank #(
    .NUM_TIMERS  (2),
    .TIMER_WIDTH (32),
    .CNT_WIDTH   (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .csr_write  (csr_write),
    .write_addr (write_addr),
    .WD         (WD),
    .read_addr  (read_addr),
    .RDout      (RDout),
    .timer_irq  (timer_irq),
    .timer_int  (timer_int),
    .timer_id   (timer_id)
  );

  always #5 clk = ~clk;

  // Reference model of the stable counter: edges seen out of reset.
  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt = 0;
    else     edge_cnt = edge_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string n, input logic [31:0] v);
    exp_t x;
    x.name = n;
    x.val  = v;
    sb.push_back(x);
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    csr_write  = 1'b1;
    write_addr = a;
    WD         = d;
  endtask

  task automatic test_reset();
    #2;
    read_addr = A_TCFG0; push("rst_tcfg0", 32'h0); #1;
    e = sb.pop_front(); checks++; if (RDout !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, RDout, e.val); end
    read_addr = A_TVAL1; push("rst_tval1", 32'h0); #1;
    e = sb.pop_front(); checks++; if (RDout !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, RDout, e.val); end
    read_addr = A_CNTVL; push("rst_cntvl", 32'h0); push("rst_int", 32'h0); push("rst_irq", 32'h0); #1;
    e = sb.pop_front(); checks++; if (RDout !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, RDout, e.val); end
    e = sb.pop_front(); checks++; if (32'(timer_int) !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, timer_int, e.val); end
    e = sb.pop_front(); checks++; if (32'(timer_irq) !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, timer_irq, e.val); end
    repeat (3) tick();
    rst = 1'b0;
    #1;
    push("cntvl_first", 32'h0); #1;
    e = sb.pop_front(); checks++; if (RDout !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, RDout, e.val); end
    repeat (7) tick();
    push("cntvl_count", edge_cnt); #1;
    e = sb.pop_front(); checks++; if (RDout !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, RDout, e.val); end
    read_addr = A_CNTVH; push("cntvh", 32'h0); #1;
    e = sb.pop_front(); checks++; if (RDout !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, RDout, e.val); end
  endtask

  task automatic test_periodic();
    wr(A_TCFG0, 32'h7);
    read_addr = A_TVAL0;
    for (int c = 0; c <= 5; c++) begin
      push($sformatf("per_tval_%0d", c), (c <= 4) ? 32'(4 - c) : 32'd4);
      push($sformatf("per_irq_%0d", c), (c == 5) ? 32'd1 : 32'd0);
    end
    tick();
    csr_write = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      #1;
      e = sb.pop_front(); checks++; if (RDout !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, RDout, e.val); end
      e = sb.pop_front(); checks++; if (32'(timer_irq[0]) !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, timer_irq[0], e.val); end
      if (c < 5) tick();
    end
    // Stop the channel: count freezes at the reload value, pending kept.
    wr(A_TCFG0, 32'h0);
    push("stop_tval0", 32'd4); push("stop_irq", 32'h1);
    tick();
    csr_write = 1'b0;
    #1;
    e = sb.pop_front(); checks++; if (RDout !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, RDout, e.val); end
    e = sb.pop_front(); checks++; if (32'(timer_irq) !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, timer_irq, e.val); end
    wr(A_TICLR0, 32'h1);
    push("clr0_irq", 32'h0);
    tick();
    csr_write = 1'b0;
    #1;
    e = sb.pop_front(); checks++; if (32'(timer_irq) !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, timer_irq, e.val); end
  endtask

  task automatic test_oneshot();
    wr(A_TCFG1, 32'h9);
    read_addr = A_TVAL1;
    for (int c = 0; c <= 9; c++) begin
      push($sformatf("os_tval_%0d", c), (c <= 8) ? 32'(8 - c) : 32'd0);
      push($sformatf("os_irq_%0d", c), (c == 9) ? 32'd1 : 32'd0);
    end
    tick();
    csr_write = 1'b0;
    for (int c = 0; c <= 9; c++) begin
      #1;
      e = sb.pop_front(); checks++; if (RDout !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, RDout, e.val); end
      e = sb.pop_front(); checks++; if (32'(timer_irq[1]) !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, timer_irq[1], e.val); end
      if (c < 9) tick();
    end
    tick();
    push("os_tval_hold", 32'h0); push("os_id", 32'd1); push("os_int", 32'd1); #1;
    e = sb.pop_front(); checks++; if (RDout !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, RDout, e.val); end
    e = sb.pop_front(); checks++; if (32'(timer_id) !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, timer_id, e.val); end
    e = sb.pop_front(); checks++; if (32'(timer_int) !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, timer_int, e.val); end
    read_addr = A_TCFG1; push("os_tcfg_en0", 32'h8); #1;
    e = sb.pop_front(); checks++; if (RDout !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, RDout, e.val); end
  endtask

  task automatic test_clear_collision();
    wr(A_TICLR1, 32'h1);
    push("pre_clr_irq", 32'h0);
    tick();
    csr_write = 1'b0;
    #1;
    e = sb.pop_front(); checks++; if (32'(timer_irq) !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, timer_irq, e.val); end
    wr(A_TCFG1, 32'h5);  // one-shot, count 4: expires on the 5th edge after load
    tick();
    csr_write = 1'b0;
    repeat (4) tick();
    wr(A_TICLR1, 32'h1);
    read_addr = A_TICLR1;
    push("ticlr_bypass", 32'h0); #1;
    e = sb.pop_front(); checks++; if (RDout !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, RDout, e.val); end
    push("collide_irq1", 32'h1);
    tick();
    csr_write = 1'b0;
    #1;
    e = sb.pop_front(); checks++; if (32'(timer_irq[1]) !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, timer_irq[1], e.val); end
    wr(A_TICLR1, 32'hFFFF_FFFE);  // bit0 clear: no effect
    push("clr_bit0_zero", 32'h1);
    tick();
    csr_write = 1'b0;
    #1;
    e = sb.pop_front(); checks++; if (32'(timer_irq[1]) !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, timer_irq[1], e.val); end
    wr(A_TICLR1, 32'h1);
    push("clr1_irq", 32'h0); push("clr1_int", 32'h0);
    tick();
    csr_write = 1'b0;
    #1;
    e = sb.pop_front(); checks++; if (32'(timer_irq) !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, timer_irq, e.val); end
    e = sb.pop_front(); checks++; if (32'(timer_int) !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, timer_int, e.val); end
  endtask

  task automatic test_bypass();
    wr(A_TCFG0, 32'h13);
    read_addr = A_TCFG0;
    push("tcfg_bypass", 32'h13); #1;
    e = sb.pop_front(); checks++; if (RDout !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, RDout, e.val); end
    tick();
    csr_write = 1'b0;
    read_addr = A_TVAL0;
    push("load_tval0", 32'd16); #1;
    e = sb.pop_front(); checks++; if (RDout !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, RDout, e.val); end
    wr(A_TCFG0, 32'h0);
    push("freeze_tval0", 32'd16);
    tick();
    csr_write = 1'b0;
    #1;
    e = sb.pop_front(); checks++; if (RDout !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, RDout, e.val); end
    read_addr = A_TCFG2; push("tcfg2_absent", 32'h0); #1;
    e = sb.pop_front(); checks++; if (RDout !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, RDout, e.val); end
    read_addr = A_TICLR0; push("ticlr0_read", 32'h0); #1;
    e = sb.pop_front(); checks++; if (RDout !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, RDout, e.val); end
    read_addr = 14'h000; push("unmapped", 32'h0); #1;
    e = sb.pop_front(); checks++; if (RDout !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, RDout, e.val); end
  endtask

  task automatic test_both_pending_and_reset();
    wr(A_TCFG1, 32'h1);  // one-shot, count 0: expires next edge
    tick();
    wr(A_TCFG0, 32'h3);  // periodic, count 0: pending every edge
    tick();
    csr_write = 1'b0;
    tick();
    push("both_irq", 32'h3); push("both_id", 32'h0); push("both_int", 32'h1); #1;
    e = sb.pop_front(); checks++; if (32'(timer_irq) !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, timer_irq, e.val); end
    e = sb.pop_front(); checks++; if (32'(timer_id) !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, timer_id, e.val); end
    e = sb.pop_front(); checks++; if (32'(timer_int) !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, timer_int, e.val); end
    wr(A_TCFG1, 32'h401);  // count 0x400
    tick();
    csr_write = 1'b0;
    repeat (3) tick();
    read_addr = A_TVAL1; push("mid_tval1", 32'h3FD); #1;
    e = sb.pop_front(); checks++; if (RDout !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, RDout, e.val); end
    // Asynchronous reset between clock edges.
    rst = 1'b1;
    push("arst_irq", 32'h0); push("arst_int", 32'h0); push("arst_tval1", 32'h0); #1;
    e = sb.pop_front(); checks++; if (32'(timer_irq) !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, timer_irq, e.val); end
    e = sb.pop_front(); checks++; if (32'(timer_int) !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, timer_int, e.val); end
    e = sb.pop_front(); checks++; if (RDout !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, RDout, e.val); end
    read_addr = A_CNTVL; push("arst_cntvl", 32'h0); #1;
    e = sb.pop_front(); checks++; if (RDout !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, RDout, e.val); end
    read_addr = A_TCFG0; push("arst_tcfg0", 32'h0); #1;
    e = sb.pop_front(); checks++; if (RDout !== e.val) begin errors++; $display("FAIL %s got %0h expected %0h", e.name, RDout, e.val); end
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired: checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_clear_collision();
    test_bypass();
    test_both_pending_and_reset();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
